hps_io_events: RTL and testbench

Parametrised successor to the Minimig HPS user-IO command decoder. It sits between the HPS user-IO strobe interface and the core. It decodes HPS commands into a configurable number of 16- or 32-bit joystick ports, button and mouse-button state, and keyboard/mouse/OSD events. Events are delivered through a ready/valid FIFO instead of a toggle level, so back-to-back events are never lost silently. Drops are counted and reported back to the HPS.

---
 rtl/hps_io_events.sv | 196 +++++++++++++++++++
 tb/tb_hps_io_events.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_io_events.sv
// HPS user-IO command decoder: joystick/button state plus a ready/valid event FIFO
// for mouse, keyboard and OSD traffic, with drop accounting readable by the HPS.
module hps_io_events #(
    parameter int NUM_JOY = 4,
    parameter int JOY32   = 0,
    parameter int EVT_AW  = 4
) (
    input  logic                                      clk_sys,
    input  logic                                      reset,
    input  logic                                      UIO_ENA,
    input  logic                                      IO_STROBE,
    input  logic [15:0]                               IO_DIN,
    output logic [15:0]                               io_dout,
    output logic [NUM_JOY*((JOY32 != 0) ? 32 : 16)-1:0] joy,
    output logic [7:0]                                buttons,
    output logic [2:0]                                mouse_buttons,
    output logic                                      evt_valid,
    output logic [1:0]                                evt_type,
    output logic [7:0]                                evt_data,
    input  logic                                      evt_ready,
    output logic                                      evt_overflow
);
    localparam int JW    = (JOY32 != 0) ? 32 : 16;
    localparam int DEPTH = 1 << EVT_AW;
    localparam logic [EVT_AW:0] PTR_ONE = 1;

    logic [5:0]  byte_cnt;
    logic [15:0] cmd;
    logic        abort;
    logic        stb, p1, p2, p3;

    // Strobes arriving after a mid-frame reset are ignored until the frame closes.
    assign stb = UIO_ENA & IO_STROBE & ~abort;
    assign p1  = stb && (byte_cnt == 6'd1);
    assign p2  = stb && (byte_cnt == 6'd2);
    assign p3  = stb && (byte_cnt == 6'd3);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byte_cnt <= '0;
            cmd      <= '0;
            abort    <= UIO_ENA;
        end else if (!UIO_ENA) begin
            byte_cnt <= '0;
            abort    <= 1'b0;
        end else if (stb) begin
            if (byte_cnt == 6'd0) cmd <= IO_DIN;
            if (byte_cnt != 6'd63) byte_cnt <= byte_cnt + 6'd1;
        end
    end

    logic          joy_sel, joy_hit, joy_wr;
    logic [2:0]    joy_idx;
    logic [JW-1:0] joy_wdata;
    logic [NUM_JOY-1:0][JW-1:0] joy_q;

    always_comb begin
        joy_sel = 1'b0;
        joy_idx = 3'd0;
        if (cmd == 16'h0002) begin
            joy_sel = 1'b1;
        end else if (cmd == 16'h0003) begin
            joy_sel = 1'b1;
            joy_idx = 3'd1;
        end else if (cmd[15:3] == 13'h0002 && cmd[2:0] <= 3'd5) begin
            joy_sel = 1'b1;
            joy_idx = cmd[2:0] + 3'd2;
        end
    end
    assign joy_hit = joy_sel && (32'(joy_idx) < NUM_JOY);

    generate
        if (JOY32 != 0) begin : g_j32
            // Low half is staged so the port changes in a single update.
            logic [15:0] joy_stage;
            always_ff @(posedge clk_sys) begin
                if (reset) joy_stage <= '0;
                else if (p1 && joy_hit) joy_stage <= IO_DIN;
            end
            assign joy_wr    = p2 && joy_hit;
            assign joy_wdata = {IO_DIN, joy_stage};
        end else begin : g_j16
            assign joy_wr    = p1 && joy_hit;
            assign joy_wdata = IO_DIN;
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_q         <= '0;
            buttons       <= '0;
            mouse_buttons <= '0;
        end else begin
            for (int k = 0; k < NUM_JOY; k++)
                if (joy_wr && joy_idx == 3'(k)) joy_q[k] <= joy_wdata;
            if (p1 && cmd == 16'h0001) buttons <= IO_DIN[7:0];
            if (p3 && cmd == 16'h0004) mouse_buttons <= IO_DIN[2:0];
        end
    end
    assign joy = joy_q;

    logic       push;
    logic [9:0] push_data;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (cmd == 16'h0004 && (p1 || p2)) begin
            push      = 1'b1;
            push_data = {p2 ? 2'd1 : 2'd0, IO_DIN[7:0]};
        end else if (cmd == 16'h0005 && p1) begin
            push      = 1'b1;
            push_data = {2'd2, IO_DIN[7:0]};
        end else if (cmd == 16'h0006 && p1) begin
            push      = 1'b1;
            push_data = {2'd3, IO_DIN[7:0]};
        end
    end

    logic [9:0]      mem [DEPTH];
    logic [EVT_AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt, cnt_nxt;
    logic            full, pop, push_acc, drop;
    logic [9:0]      head;
    logic [15:0]     free_slots;

    assign full     = (wr_ptr[EVT_AW] != rd_ptr[EVT_AW]) &&
                      (wr_ptr[EVT_AW-1:0] == rd_ptr[EVT_AW-1:0]);
    assign pop      = evt_valid & evt_ready;
    assign push_acc = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign wr_nxt   = push_acc ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_nxt   = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign cnt      = wr_ptr - rd_ptr;
    assign cnt_nxt  = wr_nxt - rd_nxt;
    // The pushed word becomes head directly when it lands in the next read slot.
    assign head     = (push_acc && wr_ptr[EVT_AW-1:0] == rd_nxt[EVT_AW-1:0]) ?
                      push_data : mem[rd_nxt[EVT_AW-1:0]];
    assign free_slots = 16'(DEPTH) - 16'(cnt) + 16'(pop);

    always_ff @(posedge clk_sys) begin
        if (push_acc) mem[wr_ptr[EVT_AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_type  <= '0;
            evt_data  <= '0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            evt_valid <= (cnt_nxt != '0);
            {evt_type, evt_data} <= (cnt_nxt != '0) ? head : 10'd0;
        end
    end

    logic [7:0] drop_cnt;
    logic       st_pend;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            drop_cnt     <= '0;
            evt_overflow <= 1'b0;
            st_pend      <= 1'b0;
        end else if (!UIO_ENA && st_pend) begin
            drop_cnt     <= '0;
            evt_overflow <= 1'b0;
            st_pend      <= 1'b0;
        end else begin
            if (drop) begin
                evt_overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            if (p2 && cmd == 16'h003A) st_pend <= 1'b1;
        end
    end

    logic [15:0] io_nxt;

    always_comb begin
        io_nxt = '0;
        if (byte_cnt == 6'd0) begin
            if (IO_DIN == 16'h002B || IO_DIN == 16'h002F) io_nxt = 16'd1;
        end else if (cmd == 16'h003A) begin
            if (byte_cnt == 6'd1)      io_nxt = free_slots;
            else if (byte_cnt == 6'd2) io_nxt = {8'h00, drop_cnt};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)    io_dout <= '0;
        else if (stb) io_dout <= io_nxt;
    end
endmodule

// File: tb/tb_hps_io_events.sv
// Directed bench: a 16-bit-joystick and a 32-bit-joystick instance share one
// HPS stimulus stream; both use a 4-deep event FIFO.
module tb_hps_io_events;
    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic UIO_ENA = 1'b0;
    logic IO_STROBE = 1'b0;
    logic [15:0] IO_DIN = '0;
    logic evt_ready = 1'b0;

    logic [15:0]  a_dout, b_dout;
    logic [63:0]  a_joy;
    logic [127:0] b_joy;
    logic [7:0]   a_btn, b_btn;
    logic [2:0]   a_mb, b_mb;
    logic         a_valid, b_valid, a_ovf, b_ovf;
    logic [1:0]   a_type, b_type;
    logic [7:0]   a_data, b_data;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    hps_io_events #(.NUM_JOY(4), .JOY32(0), .EVT_AW(2)) d16 (
        .clk_sys(clk_sys), .reset(reset), .UIO_ENA(UIO_ENA), .IO_STROBE(IO_STROBE),
        .IO_DIN(IO_DIN), .io_dout(a_dout), .joy(a_joy), .buttons(a_btn),
        .mouse_buttons(a_mb), .evt_valid(a_valid), .evt_type(a_type),
        .evt_data(a_data), .evt_ready(evt_ready), .evt_overflow(a_ovf));

    hps_io_events #(.NUM_JOY(4), .JOY32(1), .EVT_AW(2)) d32 (
        .clk_sys(clk_sys), .reset(reset), .UIO_ENA(UIO_ENA), .IO_STROBE(IO_STROBE),
        .IO_DIN(IO_DIN), .io_dout(b_dout), .joy(b_joy), .buttons(b_btn),
        .mouse_buttons(b_mb), .evt_valid(b_valid), .evt_type(b_type),
        .evt_data(b_data), .evt_ready(evt_ready), .evt_overflow(b_ovf));

    task automatic begin_frame();
        @(negedge clk_sys);
        UIO_ENA = 1'b1;
    endtask

    task automatic end_frame();
        @(negedge clk_sys);
        UIO_ENA = 1'b0;
        @(negedge clk_sys);
    endtask

    // Returns at the negedge after the strobe's clock edge.
    task automatic send_word(input logic [15:0] w, input logic rdy);
        @(negedge clk_sys);
        IO_DIN = w;
        IO_STROBE = 1'b1;
        evt_ready = rdy;
        @(negedge clk_sys);
        IO_STROBE = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (a_joy !== 64'h0 || b_joy !== 128'h0) begin
            errors++; $display("FAIL reset_joy: got %h / %h expected 0", a_joy, b_joy);
        end
        checks++;
        if ({a_btn, a_mb, a_dout} !== 27'h0) begin
            errors++; $display("FAIL reset_state: btn %h mb %h dout %h expected 0", a_btn, a_mb, a_dout);
        end
        checks++;
        if ({a_valid, a_type, a_data, a_ovf} !== 12'h0) begin
            errors++; $display("FAIL reset_fifo: valid %b type %h data %h ovf %b expected 0",
                               a_valid, a_type, a_data, a_ovf);
        end
    endtask

    task automatic test_joy16();
        begin_frame(); send_word(16'h0011, 1'b0); send_word(16'hBEEF, 1'b0); end_frame();
        checks++;
        if (a_joy !== 64'hBEEF_0000_0000_0000) begin
            errors++; $display("FAIL joy16_port3: got %h expected %h", a_joy, 64'hBEEF_0000_0000_0000);
        end
        checks++;
        if (b_joy !== 128'h0) begin
            errors++; $display("FAIL joy32_single_payload: got %h expected 0", b_joy);
        end
        begin_frame(); send_word(16'h0015, 1'b0); send_word(16'h1234, 1'b0); end_frame();
        checks++;
        if (a_joy !== 64'hBEEF_0000_0000_0000) begin
            errors++; $display("FAIL joy16_port_out_of_range: got %h expected %h", a_joy, 64'hBEEF_0000_0000_0000);
        end
        begin_frame(); send_word(16'h0001, 1'b0); send_word(16'h00A5, 1'b0); end_frame();
        checks++;
        if (a_btn !== 8'hA5) begin
            errors++; $display("FAIL buttons: got %h expected a5", a_btn);
        end
    endtask

    task automatic test_joy32();
        begin_frame(); send_word(16'h0002, 1'b0); send_word(16'h5678, 1'b0);
        checks++;
        if (b_joy[31:0] !== 32'h0) begin
            errors++; $display("FAIL joy32_early_update: got %h expected 0", b_joy[31:0]);
        end
        checks++;
        if (a_joy[15:0] !== 16'h5678) begin
            errors++; $display("FAIL joy16_port0: got %h expected 5678", a_joy[15:0]);
        end
        send_word(16'h1234, 1'b0);
        checks++;
        if (b_joy !== 128'h1234_5678) begin
            errors++; $display("FAIL joy32_port0: got %h expected 12345678", b_joy);
        end
        end_frame();
        begin_frame(); send_word(16'h0003, 1'b0); send_word(16'hAAAA, 1'b0); end_frame();
        checks++;
        if (b_joy !== 128'h1234_5678) begin
            errors++; $display("FAIL joy32_aborted_frame: got %h expected 12345678", b_joy);
        end
    endtask

    task automatic test_mouse();
        begin_frame(); send_word(16'h0004, 1'b1); send_word(16'h0005, 1'b1);
        checks++;
        if ({a_valid, a_type, a_data} !== {1'b1, 2'd0, 8'h05}) begin
            errors++; $display("FAIL mouse_x_evt: got %b/%0d/%h expected 1/0/05", a_valid, a_type, a_data);
        end
        send_word(16'h00FB, 1'b1);
        checks++;
        if ({a_valid, a_type, a_data} !== {1'b1, 2'd1, 8'hFB}) begin
            errors++; $display("FAIL mouse_y_evt: got %b/%0d/%h expected 1/1/fb", a_valid, a_type, a_data);
        end
        send_word(16'h0003, 1'b1);
        checks++;
        if (a_mb !== 3'd3 || a_valid !== 1'b0) begin
            errors++; $display("FAIL mouse_buttons: got mb %h valid %b expected 3/0", a_mb, a_valid);
        end
        end_frame();
        evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            begin_frame(); send_word(16'h0005, 1'b0); send_word(16'(16'h0010 + i), 1'b0); end_frame();
        end
        checks++;
        if ({a_valid, a_type, a_data, a_ovf} !== {1'b1, 2'd2, 8'h10, 1'b1}) begin
            errors++; $display("FAIL overflow_head: got %b/%0d/%h ovf %b expected 1/2/10 ovf 1",
                               a_valid, a_type, a_data, a_ovf);
        end
        begin_frame(); send_word(16'h003A, 1'b0); send_word(16'h0000, 1'b0);
        checks++;
        if (a_dout !== 16'h0000) begin
            errors++; $display("FAIL status_free_full: got %h expected 0000", a_dout);
        end
        send_word(16'h0000, 1'b0);
        checks++;
        if (a_dout !== 16'h0002) begin
            errors++; $display("FAIL status_drops: got %h expected 0002", a_dout);
        end
        end_frame();
        checks++;
        if (a_ovf !== 1'b0) begin
            errors++; $display("FAIL overflow_clear: got %b expected 0", a_ovf);
        end
    endtask

    task automatic test_back_to_back();
        // Push while full with a pop on the same edge.
        begin_frame(); send_word(16'h0005, 1'b0); send_word(16'h0077, 1'b1);
        evt_ready = 1'b0;
        end_frame();
        checks++;
        if ({a_valid, a_data, a_ovf} !== {1'b1, 8'h11, 1'b0}) begin
            errors++; $display("FAIL pushpop_full: got %b/%h ovf %b expected 1/11 ovf 0", a_valid, a_data, a_ovf);
        end
        begin_frame(); send_word(16'h003A, 1'b0); send_word(16'h0000, 1'b0);
        checks++;
        if (a_dout !== 16'h0000) begin
            errors++; $display("FAIL pushpop_occupancy: got %h expected 0000", a_dout);
        end
        send_word(16'h0000, 1'b0);
        checks++;
        if (a_dout !== 16'h0000) begin
            errors++; $display("FAIL pushpop_drops: got %h expected 0000", a_dout);
        end
        end_frame();
        begin_frame(); send_word(16'h002B, 1'b0);
        checks++;
        if (a_dout !== 16'h0001) begin
            errors++; $display("FAIL probe_2b: got %h expected 0001", a_dout);
        end
        send_word(16'h0000, 1'b0);
        checks++;
        if (a_dout !== 16'h0000) begin
            errors++; $display("FAIL probe_followup: got %h expected 0000", a_dout);
        end
        end_frame();
        begin_frame(); send_word(16'h002F, 1'b0);
        checks++;
        if (a_dout !== 16'h0001) begin
            errors++; $display("FAIL probe_2f: got %h expected 0001", a_dout);
        end
        end_frame();
        // Free count taken with a concurrent pop.
        begin_frame(); send_word(16'h003A, 1'b0); send_word(16'h0000, 1'b1);
        evt_ready = 1'b0;
        checks++;
        if (a_dout !== 16'h0001) begin
            errors++; $display("FAIL free_with_pop: got %h expected 0001", a_dout);
        end
        end_frame();
        checks++;
        if (a_data !== 8'h12) begin
            errors++; $display("FAIL drain_head0: got %h expected 12", a_data);
        end
        evt_ready = 1'b1;
        @(negedge clk_sys);
        checks++;
        if ({a_valid, a_data} !== {1'b1, 8'h13}) begin
            errors++; $display("FAIL drain_head1: got %b/%h expected 1/13", a_valid, a_data);
        end
        @(negedge clk_sys);
        checks++;
        if ({a_valid, a_type, a_data} !== {1'b1, 2'd2, 8'h77}) begin
            errors++; $display("FAIL drain_head2: got %b/%0d/%h expected 1/2/77", a_valid, a_type, a_data);
        end
        @(negedge clk_sys);
        checks++;
        if (a_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got %b expected 0", a_valid);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_abort();
        begin_frame(); send_word(16'h0005, 1'b0);
        @(negedge clk_sys); reset = 1'b1;
        @(negedge clk_sys); reset = 1'b0;
        send_word(16'h0002, 1'b0); send_word(16'h1111, 1'b0);
        checks++;
        if (a_joy !== 64'h0 || a_valid !== 1'b0) begin
            errors++; $display("FAIL abort_ignored: got joy %h valid %b expected 0/0", a_joy, a_valid);
        end
        end_frame();
        begin_frame(); send_word(16'h0005, 1'b0); send_word(16'h0042, 1'b0); end_frame();
        checks++;
        if ({a_valid, a_type, a_data} !== {1'b1, 2'd2, 8'h42}) begin
            errors++; $display("FAIL abort_recover_key: got %b/%0d/%h expected 1/2/42", a_valid, a_type, a_data);
        end
        begin_frame(); send_word(16'h0002, 1'b0); send_word(16'h4321, 1'b0); end_frame();
        checks++;
        if (a_joy !== 64'h4321) begin
            errors++; $display("FAIL abort_recover_joy: got %h expected 4321", a_joy);
        end
    endtask

    initial begin
        test_reset();
        test_joy16();
        test_joy32();
        test_mouse();
        test_overflow();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
